rm_lane_collector: RTL and testbench

Receiving end of the runtime-monitor event routing path. It takes the per-lane event vectors, instruction types and valids produced by the event router. It buffers each lane's per-cycle event bundle in a small per-lane FIFO. It then presents the bundles to the lane monitor engines over an independent valid/ready handshake per lane. It also tracks per-lane overflow (dropped bundles) for debug and CSR readout.

---
 rtl/rm_lane_collector_if.sv | 54 +++++
 rtl/rm_lane_collector.sv | 152 +++++++++++++++
 tb/tb_rm_lane_collector.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rm_lane_collector_if.sv
// rm_lane_collector_if
//   Bundles the event-router side inputs, the lane-engine handshake and the
//   debug/CSR readout of rm_lane_collector into one interface.
//   Ports carried (all per lane, NUM_LANES wide):
//     lane_vector0_i / lane_vector1_i : primary / secondary event bits
//     itype1_i                        : instruction type for secondary events
//     valid0_i / valid1_i             : primary / secondary bundle present
//     flush_i / clear_i               : global FIFO flush, counter clear
//     out_valid_o / out_ready_i       : head-entry handshake to lane engines
//     out_vec0_o / out_vec1_o / out_itype1_o / out_has0_o / out_has1_o : head
//     occupancy_o / drop_cnt_o / overflow_o : per-lane debug state
//   master : the producer/consumer side (router + engines).
//   slave  : the collector itself.
interface rm_lane_collector_if #(
  parameter int NUM_LANES  = 5,
  parameter int NUM_EVENTS = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
);
  localparam int IT_W  = $clog2(NUM_EVENTS);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] lane_vector0_i;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] lane_vector1_i;
  logic [NUM_LANES-1:0][IT_W-1:0]       itype1_i;
  logic [NUM_LANES-1:0]                 valid0_i;
  logic [NUM_LANES-1:0]                 valid1_i;
  logic                                 flush_i;
  logic                                 clear_i;
  logic [NUM_LANES-1:0]                 out_valid_o;
  logic [NUM_LANES-1:0]                 out_ready_i;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] out_vec0_o;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] out_vec1_o;
  logic [NUM_LANES-1:0][IT_W-1:0]       out_itype1_o;
  logic [NUM_LANES-1:0]                 out_has0_o;
  logic [NUM_LANES-1:0]                 out_has1_o;
  logic [NUM_LANES-1:0][OCC_W-1:0]      occupancy_o;
  logic [NUM_LANES-1:0][CNT_W-1:0]      drop_cnt_o;
  logic [NUM_LANES-1:0]                 overflow_o;

  modport master (
    output lane_vector0_i, lane_vector1_i, itype1_i, valid0_i, valid1_i,
    output flush_i, clear_i, out_ready_i,
    input  out_valid_o, out_vec0_o, out_vec1_o, out_itype1_o,
    input  out_has0_o, out_has1_o, occupancy_o, drop_cnt_o, overflow_o
  );

  modport slave (
    input  lane_vector0_i, lane_vector1_i, itype1_i, valid0_i, valid1_i,
    input  flush_i, clear_i, out_ready_i,
    output out_valid_o, out_vec0_o, out_vec1_o, out_itype1_o,
    output out_has0_o, out_has1_o, occupancy_o, drop_cnt_o, overflow_o
  );
endinterface

// File: rtl/rm_lane_collector.sv
// rm_lane_collector
//   Receiving end of the runtime-monitor event routing path. Each lane owns a
//   small first-word-fall-through FIFO of event bundles which is drained by
//   that lane's monitor engine over a valid/ready handshake. Bundles that
//   arrive while a lane FIFO is full (and not being popped) are dropped and
//   counted in a saturating per-lane counter with a sticky overflow flag.
//   Ports:
//     clk_i  : clock
//     rst_ni : synchronous active-low reset
//     bus    : rm_lane_collector_if.slave (router inputs, lane handshake,
//              occupancy / drop counter / overflow readout)
module rm_lane_collector #(
  parameter int NUM_LANES  = 5,
  parameter int NUM_EVENTS = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  rm_lane_collector_if.slave bus
);

  localparam int IT_W    = $clog2(NUM_EVENTS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * NUM_EVENTS + IT_W + 2;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  // Storage is deliberately left out of reset; occupancy alone decides
  // which entries are live.
  logic [ENTRY_W-1:0] mem_q [NUM_LANES][FIFO_DEPTH];

  logic [NUM_LANES-1:0][PTR_W-1:0]  wr_ptr_q;
  logic [NUM_LANES-1:0][PTR_W-1:0]  rd_ptr_q;
  logic [NUM_LANES-1:0][OCC_W-1:0]  occ_q;
  logic [NUM_LANES-1:0][CNT_W-1:0]  drop_cnt_q;
  logic [NUM_LANES-1:0]             overflow_q;

  logic [NUM_LANES-1:0]             push;
  logic [NUM_LANES-1:0]             pop;
  logic [NUM_LANES-1:0]             full;
  logic [NUM_LANES-1:0]             accept;
  logic [NUM_LANES-1:0]             drop;
  logic [NUM_LANES-1:0][ENTRY_W-1:0] wr_entry;
  logic [NUM_LANES-1:0][ENTRY_W-1:0] head;

  logic [NUM_LANES-1:0]                 out_valid;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] out_vec0;
  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] out_vec1;
  logic [NUM_LANES-1:0][IT_W-1:0]       out_itype1;
  logic [NUM_LANES-1:0]                 out_has0;
  logic [NUM_LANES-1:0]                 out_has1;

  // Per-lane push/pop decisions and head unpacking. A full FIFO still takes
  // a push when its head leaves in the same cycle, since the freed slot is
  // the one the write pointer is sitting on. Flush overrides both sides, so
  // a bundle arriving during flush is neither stored nor counted as a drop.
  always_comb begin
    push       = '0;
    pop        = '0;
    full       = '0;
    accept     = '0;
    drop       = '0;
    wr_entry   = '0;
    head       = '0;
    out_valid  = '0;
    out_vec0   = '0;
    out_vec1   = '0;
    out_itype1 = '0;
    out_has0   = '0;
    out_has1   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      push[l]   = bus.valid0_i[l] | bus.valid1_i[l];
      full[l]   = (occ_q[l] == OCC_FULL);
      out_valid[l] = (occ_q[l] != '0);
      pop[l]    = out_valid[l] & bus.out_ready_i[l] & ~bus.flush_i;
      accept[l] = push[l] & (~full[l] | pop[l]) & ~bus.flush_i;
      drop[l]   = push[l] & full[l] & ~pop[l] & ~bus.flush_i;
      wr_entry[l] = {bus.lane_vector0_i[l], bus.lane_vector1_i[l],
                     bus.itype1_i[l], bus.valid0_i[l], bus.valid1_i[l]};
      head[l]       = mem_q[l][rd_ptr_q[l]];
      out_vec0[l]   = head[l][ENTRY_W-1 -: NUM_EVENTS];
      out_vec1[l]   = head[l][IT_W+2+NUM_EVENTS-1 -: NUM_EVENTS];
      out_itype1[l] = head[l][IT_W+1 -: IT_W];
      out_has0[l]   = head[l][1];
      out_has1[l]   = head[l][0];
    end
  end

  // Entry storage: only accepted bundles are written, at the write pointer.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (rst_ni && accept[l]) begin
        mem_q[l][wr_ptr_q[l]] <= wr_entry[l];
      end
    end
  end

  // Pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH because
  // the depth is a power of two; occupancy is tracked separately so full and
  // empty are never ambiguous.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (accept[l]) begin
          wr_ptr_q[l] <= wr_ptr_q[l] + PTR_W'(1);
        end
        if (pop[l]) begin
          rd_ptr_q[l] <= rd_ptr_q[l] + PTR_W'(1);
        end
        if (accept[l] && !pop[l]) begin
          occ_q[l] <= occ_q[l] + OCC_W'(1);
        end else if (!accept[l] && pop[l]) begin
          occ_q[l] <= occ_q[l] - OCC_W'(1);
        end
      end
    end
  end

  // Drop accounting. Clear wins over a drop in the same cycle; the counter
  // holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clear_i) begin
      drop_cnt_q <= '0;
      overflow_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (drop[l]) begin
          overflow_q[l] <= 1'b1;
          if (drop_cnt_q[l] != '1) begin
            drop_cnt_q[l] <= drop_cnt_q[l] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.out_valid_o  = out_valid;
  assign bus.out_vec0_o   = out_vec0;
  assign bus.out_vec1_o   = out_vec1;
  assign bus.out_itype1_o = out_itype1;
  assign bus.out_has0_o   = out_has0;
  assign bus.out_has1_o   = out_has1;
  assign bus.occupancy_o  = occ_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_rm_lane_collector.sv
// tb_rm_lane_collector
//   Self-checking bench for rm_lane_collector. A queue-per-lane model tracks
//   what every lane must hold; a compare process checks all lane outputs
//   against it on every falling edge. Directed sequences add literal
//   expectations, then a randomized phase exercises flush/clear/reset mixes.
module tb_rm_lane_collector;

  localparam int NL    = 5;
  localparam int NE    = 10;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int OW    = 3;

  typedef struct packed {
    logic [NE-1:0] vec0;
    logic [NE-1:0] vec1;
    logic [IW-1:0] itype;
    logic          has0;
    logic          has1;
  } entry_t;

  logic clk;
  logic rst_ni;

  rm_lane_collector_if #(.NUM_LANES(NL), .NUM_EVENTS(NE), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) bus ();

  rm_lane_collector #(.NUM_LANES(NL), .NUM_EVENTS(NE), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t mq [NL][$];
  int     mcnt [NL];
  bit     movf [NL];
  bit     model_ok;

  // Stimulus data applied with the next applyStimulus call
  logic [NL-1:0][NE-1:0] d0;
  logic [NL-1:0][NE-1:0] d1;
  logic [NL-1:0][IW-1:0] itv;

  entry_t exp_e;
  entry_t act_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, returns 1ns later.
  task automatic applyStimulus(input logic [NL-1:0] v0, input logic [NL-1:0] v1,
                               input logic [NL-1:0] rdy, input logic fl,
                               input logic clr, input logic rst);
    bus.lane_vector0_i = d0;
    bus.lane_vector1_i = d1;
    bus.itype1_i       = itv;
    bus.valid0_i       = v0;
    bus.valid1_i       = v1;
    bus.out_ready_i    = rdy;
    bus.flush_i        = fl;
    bus.clear_i        = clr;
    rst_ni             = rst;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: each lane is a bounded queue of bundles.
  initial begin
    model_ok = 1'b0;
    forever begin
      @(posedge clk);
      for (int l = 0; l < NL; l++) begin
        bit     push_m, pop_m, full_m, drop_m;
        entry_t e;
        push_m = bus.valid0_i[l] | bus.valid1_i[l];
        e = '{vec0: bus.lane_vector0_i[l], vec1: bus.lane_vector1_i[l],
              itype: bus.itype1_i[l], has0: bus.valid0_i[l], has1: bus.valid1_i[l]};
        if (!rst_ni) begin
          mq[l].delete();
          mcnt[l] = 0;
          movf[l] = 1'b0;
        end else begin
          drop_m = 1'b0;
          if (bus.flush_i) begin
            mq[l].delete();
          end else begin
            full_m = (mq[l].size() == DEPTH);
            pop_m  = (mq[l].size() != 0) && bus.out_ready_i[l];
            drop_m = push_m && full_m && !pop_m;
            if (pop_m) void'(mq[l].pop_front());
            if (push_m && !drop_m) mq[l].push_back(e);
          end
          if (bus.clear_i) begin
            mcnt[l] = 0;
            movf[l] = 1'b0;
          end else if (drop_m) begin
            if (mcnt[l] != (1 << CW) - 1) mcnt[l] = mcnt[l] + 1;
            movf[l] = 1'b1;
          end
        end
      end
      if (!rst_ni) model_ok = 1'b1;
    end
  end

  // Compare process: every lane, every cycle once the model is anchored.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int l = 0; l < NL; l++) begin
          checkOutput($sformatf("occupancy[%0d]", l), 32'(bus.occupancy_o[l]), 32'(mq[l].size()));
          checkOutput($sformatf("out_valid[%0d]", l), 32'(bus.out_valid_o[l]), 32'(mq[l].size() != 0));
          checkOutput($sformatf("drop_cnt[%0d]", l), 32'(bus.drop_cnt_o[l]), 32'(mcnt[l]));
          checkOutput($sformatf("overflow[%0d]", l), 32'(bus.overflow_o[l]), 32'(movf[l]));
          if (mq[l].size() != 0) begin
            exp_e = mq[l][0];
            act_e = {bus.out_vec0_o[l], bus.out_vec1_o[l], bus.out_itype1_o[l],
                     bus.out_has0_o[l], bus.out_has1_o[l]};
            checkOutput($sformatf("head[%0d]", l), 32'(act_e), 32'(exp_e));
          end
        end
      end
    end
  end

  initial begin
    d0  = '0;
    d1  = '0;
    itv = '0;
    rst_ni = 1'b0;
    bus.lane_vector0_i = '0;
    bus.lane_vector1_i = '0;
    bus.itype1_i       = '0;
    bus.valid0_i       = '0;
    bus.valid1_i       = '0;
    bus.out_ready_i    = '0;
    bus.flush_i        = 1'b0;
    bus.clear_i        = 1'b0;

    $display("[TB] reset");
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
    checkOutput("rst_overflow", 32'(bus.overflow_o), 32'h0);
    for (int l = 0; l < NL; l++) begin
      checkOutput($sformatf("rst_occ[%0d]", l), 32'(bus.occupancy_o[l]), 32'h0);
      checkOutput($sformatf("rst_drop[%0d]", l), 32'(bus.drop_cnt_o[l]), 32'h0);
    end

    $display("[TB] single push lane 2");
    d0[2] = 10'h005;
    applyStimulus(5'b00100, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_out_valid", 32'(bus.out_valid_o), 32'h04);
    checkOutput("t1_vec0", 32'(bus.out_vec0_o[2]), 32'h005);
    checkOutput("t1_has0", 32'(bus.out_has0_o[2]), 32'h1);
    checkOutput("t1_has1", 32'(bus.out_has1_o[2]), 32'h0);
    checkOutput("t1_occ", 32'(bus.occupancy_o[2]), 32'h1);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_flush_valid", 32'(bus.out_valid_o), 32'h0);

    $display("[TB] two-lane bundle");
    d0[0] = 10'h3a1;
    d1[3] = 10'h200;
    itv[3] = 4'd7;
    applyStimulus(5'b00001, 5'b01000, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_occ0", 32'(bus.occupancy_o[0]), 32'h1);
    checkOutput("t2_occ3", 32'(bus.occupancy_o[3]), 32'h1);
    checkOutput("t2_has1_3", 32'(bus.out_has1_o[3]), 32'h1);
    checkOutput("t2_has0_3", 32'(bus.out_has0_o[3]), 32'h0);
    checkOutput("t2_itype3", 32'(bus.out_itype1_o[3]), 32'h7);
    checkOutput("t2_vec1_3", 32'(bus.out_vec1_o[3]), 32'h200);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1);

    $display("[TB] fill and overflow lane 1");
    for (int i = 0; i < 6; i++) begin
      d0[1] = 10'(i + 1);
      applyStimulus(5'b00010, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t3_occ1", 32'(bus.occupancy_o[1]), 32'h4);
    checkOutput("t3_drop1", 32'(bus.drop_cnt_o[1]), 32'h2);
    checkOutput("t3_ovf1", 32'(bus.overflow_o[1]), 32'h1);
    checkOutput("t3_model_occ1", 32'(mq[1].size()), 32'h4);
    checkOutput("t3_model_drop1", 32'(mcnt[1]), 32'h2);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_drain_valid%0d", i), 32'(bus.out_valid_o[1]), 32'h1);
      checkOutput($sformatf("t3_drain_vec%0d", i), 32'(bus.out_vec0_o[1]), 32'(i + 1));
      applyStimulus('0, '0, 5'b00010, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t3_empty", 32'(bus.out_valid_o[1]), 32'h0);

    $display("[TB] full lane 4 with push and pop");
    for (int i = 0; i < 4; i++) begin
      d0[4] = 10'h010 + 10'(i);
      applyStimulus(5'b10000, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t4_occ_full", 32'(bus.occupancy_o[4]), 32'h4);
    d0[4] = 10'h014;
    applyStimulus(5'b10000, '0, 5'b10000, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_occ_after", 32'(bus.occupancy_o[4]), 32'h4);
    checkOutput("t4_drop", 32'(bus.drop_cnt_o[4]), 32'h0);
    checkOutput("t4_head", 32'(bus.out_vec0_o[4]), 32'h011);

    $display("[TB] flush with concurrent push");
    for (int i = 0; i < 3; i++) begin
      d0[0] = 10'h030 + 10'(i);
      applyStimulus(5'b00001, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t5_occ0", 32'(bus.occupancy_o[0]), 32'h3);
    applyStimulus(5'b10001, '0, 5'b00001, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_occ0_flushed", 32'(bus.occupancy_o[0]), 32'h0);
    checkOutput("t5_occ4_flushed", 32'(bus.occupancy_o[4]), 32'h0);
    checkOutput("t5_drop0", 32'(bus.drop_cnt_o[0]), 32'h0);
    checkOutput("t5_drop4", 32'(bus.drop_cnt_o[4]), 32'h0);
    checkOutput("t5_drop1_kept", 32'(bus.drop_cnt_o[1]), 32'h2);
    checkOutput("t5_ovf_kept", 32'(bus.overflow_o), 32'h02);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_clr_ovf", 32'(bus.overflow_o), 32'h0);
    for (int l = 0; l < NL; l++)
      checkOutput($sformatf("t5_clr_drop[%0d]", l), 32'(bus.drop_cnt_o[l]), 32'h0);

    $display("[TB] drop versus clear");
    for (int i = 0; i < 5; i++) begin
      d0[4] = 10'h050 + 10'(i);
      applyStimulus(5'b10000, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t5b_drop4", 32'(bus.drop_cnt_o[4]), 32'h1);
    checkOutput("t5b_ovf4", 32'(bus.overflow_o[4]), 32'h1);
    applyStimulus(5'b10000, '0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5b_clr_drop4", 32'(bus.drop_cnt_o[4]), 32'h0);
    checkOutput("t5b_clr_ovf4", 32'(bus.overflow_o[4]), 32'h0);
    checkOutput("t5b_occ4", 32'(bus.occupancy_o[4]), 32'h4);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) begin
      d1[3] = 10'h060 + 10'(i);
      applyStimulus('0, 5'b01000, '0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t6_drop3", 32'(bus.drop_cnt_o[3]), 32'h1);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      for (int l = 0; l < NL; l++) d0[l] = 10'(8 * l + i);
      applyStimulus(5'b11111, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    for (int l = 0; l < NL; l++)
      checkOutput($sformatf("t6_occ2[%0d]", l), 32'(bus.occupancy_o[l]), 32'h2);
    applyStimulus(5'b11111, '0, 5'b01010, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_rst_valid", 32'(bus.out_valid_o), 32'h0);
    checkOutput("t6_rst_ovf", 32'(bus.overflow_o), 32'h0);
    for (int l = 0; l < NL; l++) begin
      checkOutput($sformatf("t6_rst_occ[%0d]", l), 32'(bus.occupancy_o[l]), 32'h0);
      checkOutput($sformatf("t6_rst_drop[%0d]", l), 32'(bus.drop_cnt_o[l]), 32'h0);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [NL-1:0] v0, v1, rdy;
      logic fl, clr, rst;
      for (int l = 0; l < NL; l++) begin
        d0[l]  = NE'($urandom);
        d1[l]  = NE'($urandom);
        itv[l] = IW'($urandom);
      end
      v0  = NL'($urandom);
      v1  = NL'($urandom) & NL'($urandom);
      rdy = (c < 1500) ? (NL'($urandom) & NL'($urandom)) : (NL'($urandom) | NL'($urandom));
      fl  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 399) != 0);
      applyStimulus(v0, v1, rdy, fl, clr, rst);
    end

    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
